store_buffer: RTL and testbench
===============================

# store_buffer

Write-side counterpart of the load path in the MIPS MEM stage. Accepts `sw`/`sh`/`sb` stores from the pipeline, converts each into a word-aligned address, 4-bit byte enable and lane-replicated write data, and queues them in a small FIFO. The FIFO drains to the data-memory write port over a req/ack handshake. It also flags loads that hit a pending store word so the pipeline can stall until that store has drained.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request from MEM stage.
- `st_ready` out 1: store can be accepted (= not full).
- `st_type` in 4: store kind, `memsb_sw` / `memsb_sh` / `memsb_sb` encodings from `define.v`.
- `st_addr` in 32: byte address (ALU result).
- `st_data` in 32: rt value.
- `st_misalign` out 1: one-cycle pulse; accepted store was misaligned and dropped.
- `ld_valid` in 1: a load is in MEM this cycle.
- `ld_addr` in 32: load byte address.
- `ld_hazard` out 1: combinational; load word matches a queued entry.
- `mem_req` out 1: head entry valid toward memory.
- `mem_ack` in 1: memory consumed head this cycle.
- `mem_addr` out 32: `{head_addr[31:2], 2'b00}`.
- `mem_be` out 4: head byte enables.
- `mem_wdata` out 32: head write data.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `empty` out 1: count == 0.

## Operation
- Accept on `st_valid && st_ready` with a legal `st_type`. Illegal `st_type` is ignored (no enqueue, no pulse).
- Lane formation:
  - `sb`: `be = 4'b0001 << addr[1:0]`, `wdata = {4{data[7:0]}}`.
  - `sh`: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{data[15:0]}}`.
  - `sw`: `be = 4'b1111`, `wdata = data`.
- Entry stores `{addr[31:2], be, wdata}`.
- Drain: `mem_req = !empty`. Payload is taken from head registers and is stable while `mem_req && !mem_ack`. On `mem_ack` the head pointer advances. Back-to-back acks drain one entry per cycle. `mem_ack` while `!mem_req` is ignored.
- Full: `st_ready = 0` even if `mem_ack` is high the same cycle; no same-cycle pass-through.
- Simultaneous enqueue and dequeue when not full or empty: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- `ld_hazard = ld_valid && OR over occupied entries (entry.addr[31:2] == ld_addr[31:2])`. The entry being acked this cycle still counts.

## Timing
- Reset values: pointers 0, `count` 0, `empty` 1, `mem_req` 0, `mem_be` 0, `mem_wdata` 0, `mem_addr` 0, `st_misalign` 0, `st_ready` 1.
- Enqueue latency: a store accepted at edge N into an empty FIFO gives `mem_req = 1` after edge N.
- `st_misalign` is registered: it is high for the one cycle after the accepting edge.
- Reset asserted mid-operation: all entries are discarded immediately (async). `mem_req` falls without waiting for `mem_ack`.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - `sh` with `addr[0] = 1`, or `sw` with `addr[1:0] != 0`, is accepted (`st_ready` honored) but not enqueued.
  - `st_misalign` pulses for such stores.
- Undefined:
  - `st_misalign` is tied 0.
  - `sh` ignores `addr[0]`; `sw` ignores `addr[1:0]`. Both are enqueued normally.

## Structure
- `define.v` gains the `memsb_sw`/`memsb_sh`/`memsb_sb` constants (4-bit) alongside the existing `memlb_*` encodings.
- Sub-module `store_align`: combinational lane formation plus misalignment detect. The top level holds the FIFO, pointers, counter and hazard compare.

## Test plan
- **Byte lanes:** `sb` at `0x0000_1003` with data `0x1234_56AB` → `mem_addr 0x0000_1000`, `be 4'b1000`, `wdata 0xABAB_ABAB`.
- **Half lanes:** `sh` at `0x0000_2002` with data `0xFFFF_BEEF` → `be 4'b1100`, `wdata 0xBEEF_BEEF`. `sw` at `0x0000_2004` → `be 4'b1111`, data unchanged.
- **Full / wrap:** hold `mem_ack = 0`, issue 5 stores → `st_ready` drops after the 4th and `count = 4`. Then ack 4 times → entries come out in FIFO order and `empty = 1`. Then 6 more stores with `mem_ack` held high → all drain in order across the pointer wrap.
- **Misalign:** `sw` at `0x0000_3002`:
  - With the macro: `st_misalign` pulses for 1 cycle and `count` stays 0.
  - Without the macro: entry has `mem_addr 0x0000_3000`, `be 4'b1111`.
- **Hazard:** queue `sb` to `0x0000_4001`; load at `0x0000_4002` → `ld_hazard = 1`; load at `0x0000_4004` → 0. After ack, the same `0x0000_4002` load gives `ld_hazard = 0`.
- **Reset mid-drain:** 3 entries queued with `mem_req` high; assert `reset_n = 0` mid-cycle → `mem_req`, `count` and `mem_be` go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared widths, store-kind encodings and FIFO entry layout for the MEM-stage store buffer.
package store_buffer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned TYPE_W = 4;

    // Store kinds; these sit beside the memlb_* load encodings of define.v
    localparam logic [TYPE_W-1:0] memsb_sb = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] memsb_sh = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] memsb_sw = TYPE_W'(7);

    typedef struct packed {
        logic [ADDR_W-3:0] waddr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// Lane formation for sb/sh/sw stores plus misalignment detect.
// Misalignment is only reported when STORE_ALIGN_CHECK_EN is defined.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [TYPE_W-1:0] st_type,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output sb_entry_t         entry_c,
    output logic              legal_c,
    output logic              misalign_c
);

    always_comb begin
        entry_c       = '0;
        legal_c       = 1'b0;
        misalign_c    = 1'b0;
        entry_c.waddr = st_addr[ADDR_W-1:2];
        case (st_type)
            memsb_sb: begin
                legal_c       = 1'b1;
                entry_c.be    = BE_W'(4'b0001 << st_addr[1:0]);
                entry_c.wdata = {4{st_data[7:0]}};
            end
            memsb_sh: begin
                legal_c       = 1'b1;
                entry_c.be    = st_addr[1] ? 4'b1100 : 4'b0011;
                entry_c.wdata = {2{st_data[15:0]}};
`ifdef STORE_ALIGN_CHECK_EN
                misalign_c    = st_addr[0];
`endif
            end
            memsb_sw: begin
                legal_c       = 1'b1;
                entry_c.be    = 4'b1111;
                entry_c.wdata = st_data;
`ifdef STORE_ALIGN_CHECK_EN
                misalign_c    = (st_addr[1:0] != 2'b00);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: FIFO of word-aligned stores draining over req/ack, with load-hit detect.
// Define STORE_ALIGN_CHECK_EN to drop misaligned sh/sw and pulse st_misalign.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [TYPE_W-1:0]        st_type,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_misalign,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hazard,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BE_W-1:0]          mem_be,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               misalign_q, misalign_d;

    sb_entry_t          entry_c;
    logic               legal_c, misalign_c;
    logic               accept, enq, deq;
    sb_entry_t          head_entry;
    logic               ld_lo_unused;

    store_align u_align (
        .st_type    (st_type),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .entry_c    (entry_c),
        .legal_c    (legal_c),
        .misalign_c (misalign_c)
    );

    assign st_ready   = (count_q != CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign mem_req    = !empty;
    assign count      = count_q;
    assign st_misalign = misalign_q;

    assign head_entry = entries_q[head_q];
    assign mem_addr   = {head_entry.waddr, 2'b00};
    assign mem_be     = head_entry.be;
    assign mem_wdata  = head_entry.wdata;

    assign accept = st_valid && st_ready && legal_c;
    assign enq    = accept && !misalign_c;
    assign deq    = mem_req && mem_ack;

    // Next-state: enqueue at tail, dequeue at head, occupancy tracks both
    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        misalign_d = accept && misalign_c;
        if (enq) begin
            entries_d[tail_q] = entry_c;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q  <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // An entry is occupied when its distance from head is below count; the acked head still counts
    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(PTR_W'(i) - head_q) < count_q &&
                entries_q[i].waddr == ld_addr[ADDR_W-1:2]) begin
                ld_hazard = ld_valid;
            end
        end
    end

    assign ld_lo_unused = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model checked every cycle.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
`ifdef STORE_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [3:0]  st_type = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_misalign;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_hazard;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues of what memory must see, in order
    logic [31:0] q_addr [$];
    logic [3:0]  q_be   [$];
    logic [31:0] q_data [$];
    bit          exp_mis = 1'b0;
    bit          m_acc, m_mis, m_hz;

    function automatic bit legal(input logic [3:0] t);
        return t == memsb_sb || t == memsb_sh || t == memsb_sw;
    endfunction

    function automatic bit misaligned(input logic [3:0] t, input logic [31:0] a);
        return ALIGN_EN && ((t == memsb_sh && (a % 2) != 0) || (t == memsb_sw && (a % 4) != 0));
    endfunction

    function automatic logic [3:0] lane_be(input logic [3:0] t, input logic [31:0] a);
        if (t == memsb_sb) return 4'(1 << (a % 4));
        if (t == memsb_sh) return ((a & 32'h2) != 0) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] lane_data(input logic [3:0] t, input logic [31:0] d);
        if (t == memsb_sb) return (d & 32'hFF) * 32'h0101_0101;
        if (t == memsb_sh) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_addr.delete(); q_be.delete(); q_data.delete();
            exp_mis = 1'b0;
        end else begin
            m_acc = st_valid && (q_addr.size() < DEPTH) && legal(st_type);
            m_mis = misaligned(st_type, st_addr);
            exp_mis = m_acc && m_mis;
            if (q_addr.size() > 0 && mem_ack) begin
                void'(q_addr.pop_front()); void'(q_be.pop_front()); void'(q_data.pop_front());
            end
            if (m_acc && !m_mis) begin
                q_addr.push_back(st_addr & ~32'h3);
                q_be.push_back(lane_be(st_type, st_addr));
                q_data.push_back(lane_data(st_type, st_data));
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            m_hz = 1'b0;
            foreach (q_addr[i]) if (q_addr[i][31:2] == ld_addr[31:2]) m_hz = ld_valid;
            check("count", 32'(count), 32'(q_addr.size()));
            check("empty", 32'(empty), 32'(q_addr.size() == 0));
            check("st_ready", 32'(st_ready), 32'(q_addr.size() < DEPTH));
            check("mem_req", 32'(mem_req), 32'(q_addr.size() > 0));
            check("st_misalign", 32'(st_misalign), 32'(exp_mis));
            check("ld_hazard", 32'(ld_hazard), 32'(m_hz));
            if (q_addr.size() > 0) begin
                check("mem_addr", mem_addr, q_addr[0]);
                check("mem_be", 32'(mem_be), 32'(q_be[0]));
                check("mem_wdata", mem_wdata, q_data[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_type = t; st_addr = a; st_data = d;
        cyc();
        st_valid = 1'b0;
    endtask

    task automatic ack_n(input int n);
        mem_ack = 1'b1;
        repeat (n) cyc();
        mem_ack = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_misalign", 32'(st_misalign), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc();

        // Byte lanes
        store(memsb_sb, 32'h0000_1003, 32'h1234_56AB);
        check("sb_req", 32'(mem_req), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_be", 32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        ack_n(1);

        // Half and word lanes
        store(memsb_sh, 32'h0000_2002, 32'hFFFF_BEEF);
        store(memsb_sw, 32'h0000_2004, 32'hCAFE_F00D);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        ack_n(1);
        check("sw_addr", mem_addr, 32'h0000_2004);
        check("sw_be", 32'(mem_be), 32'hF);
        check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        ack_n(1);

        // Illegal store kind is ignored
        store(4'hF, 32'h0000_7000, 32'h1111_1111);
        check("illegal_count", 32'(count), 32'd0);

        // Fill to full, fifth store refused, then drain in order
        for (int i = 0; i < 5; i++) begin
            store(memsb_sw, 32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            if (i == 3) begin
                check("full_ready", 32'(st_ready), 32'd0);
                check("full_count", 32'(count), 32'd4);
            end
        end
        check("full_count_after5", 32'(count), 32'd4);
        ack_n(4);
        check("drained_empty", 32'(empty), 32'd1);

        // Streaming with ack held high across the pointer wrap
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            store(memsb_sb, 32'h0000_8000 + 32'(i), 32'h0000_0050 + 32'(i));
            check("stream_count", 32'(count), 32'd1);
        end
        cyc();
        mem_ack = 1'b0;
        check("stream_empty", 32'(empty), 32'd1);

        // Misaligned word store
        store(memsb_sw, 32'h0000_3002, 32'h0BAD_F00D);
        if (ALIGN_EN) begin
            check("mis_pulse", 32'(st_misalign), 32'd1);
            check("mis_count", 32'(count), 32'd0);
            cyc();
            check("mis_pulse_end", 32'(st_misalign), 32'd0);
        end else begin
            check("mis_addr", mem_addr, 32'h0000_3000);
            check("mis_be", 32'(mem_be), 32'hF);
            check("mis_flag", 32'(st_misalign), 32'd0);
            ack_n(1);
        end

        // Load hazard against a queued store word
        store(memsb_sb, 32'h0000_4001, 32'h0000_0077);
        ld_valid = 1'b1; ld_addr = 32'h0000_4002;
        #1 check("hz_hit", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h0000_4004;
        #1 check("hz_miss", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h0000_4002; mem_ack = 1'b1;
        #1 check("hz_acking", 32'(ld_hazard), 32'd1);
        cyc();
        mem_ack = 1'b0;
        #1 check("hz_after_ack", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;

        // Asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) store(memsb_sw, 32'h0000_6000 + 32'(4 * i), 32'(i + 1));
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        check("pre_rst_count", 32'(count), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
